// File: rtl/xbar_cfg_loader.sv
// Crossbar configuration loader: streams NUM_OUT select words into a shadow
// register and commits them atomically to the active crossbar config.
module xbar_cfg_loader #(
    parameter int NUM_IN  = 34,
    parameter int NUM_OUT = 45,
    parameter int SEL_W   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_start,
    input  logic                     io_abort,
    input  logic                     io_cfg_valid,
    output logic                     io_cfg_ready,
    input  logic [SEL_W-1:0]         io_cfg_data,
    output logic                     io_busy,
    output logic                     io_done,
    output logic                     io_err,
    output logic [NUM_OUT*SEL_W-1:0] io_mux_configs
);

    localparam int CNT_W = $clog2(NUM_OUT + 1);
    localparam logic [SEL_W:0] IN_LIMIT = (SEL_W + 1)'(NUM_IN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]         count;
    logic [NUM_OUT*SEL_W-1:0] shadow;
    logic                     accept;
    logic                     data_bad;

    // Abort wins over a word presented in the same cycle.
    assign accept   = io_cfg_ready && io_cfg_valid && !io_abort;
    assign data_bad = {1'b0, io_cfg_data} >= IN_LIMIT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (io_start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (io_abort) begin
                    next_state = IDLE;
                end else if (io_cfg_valid && count == LAST_IDX) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        io_cfg_ready = (state == LOAD);
        io_busy      = (state != IDLE);
    end

    // The active config only moves at the end of a clean COMMIT, so the
    // crossbar never observes a half-written shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            count          <= '0;
            shadow         <= '0;
            io_err         <= 1'b0;
            io_done        <= 1'b0;
            io_mux_configs <= '0;
        end else begin
            io_done <= (state == COMMIT);
            if (state == IDLE && io_start) begin
                count  <= '0;
                io_err <= 1'b0;
            end
            if (accept) begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (count == CNT_W'(k)) begin
                        shadow[k*SEL_W +: SEL_W] <= io_cfg_data;
                    end
                end
                count <= count + 1'b1;
                if (data_bad) begin
                    io_err <= 1'b1;
                end
            end
            if (state == COMMIT && !io_err) begin
                io_mux_configs <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Directed bench for xbar_cfg_loader: full, error, abort, reset and
// ignored-start loads with hand-computed expected configurations.
module tb_xbar_cfg_loader;

    localparam int NUM_IN  = 34;
    localparam int NUM_OUT = 45;
    localparam int SEL_W   = 6;
    localparam int CFG_W   = NUM_OUT * SEL_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             io_start;
    logic             io_abort;
    logic             io_cfg_valid;
    logic             io_cfg_ready;
    logic [SEL_W-1:0] io_cfg_data;
    logic             io_busy;
    logic             io_done;
    logic             io_err;
    logic [CFG_W-1:0] io_mux_configs;

    int test_count = 0;
    int fail_count = 0;
    int done_seen  = 0;

    logic [CFG_W-1:0] exp_a;
    logic [CFG_W-1:0] exp_c;
    logic [CFG_W-1:0] zero_cfg;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (io_done === 1'b1) begin
            done_seen <= done_seen + 1;
        end
    end

    xbar_cfg_loader #(
        .NUM_IN (NUM_IN),
        .NUM_OUT(NUM_OUT),
        .SEL_W  (SEL_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_start      (io_start),
        .io_abort      (io_abort),
        .io_cfg_valid  (io_cfg_valid),
        .io_cfg_ready  (io_cfg_ready),
        .io_cfg_data   (io_cfg_data),
        .io_busy       (io_busy),
        .io_done       (io_done),
        .io_err        (io_err),
        .io_mux_configs(io_mux_configs)
    );

    function automatic logic [SEL_W-1:0] word_val(input int pattern, input int k);
        case (pattern)
            0:       return SEL_W'(k % NUM_IN);
            1:       return SEL_W'((k + 1) % NUM_IN);
            default: return SEL_W'((k * 7) % NUM_IN);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic start, input logic abort,
                                  input logic valid, input logic [SEL_W-1:0] data);
        io_start     = start;
        io_abort     = abort;
        io_cfg_valid = valid;
        io_cfg_data  = data;
        tick();
    endtask

    task automatic send_words(input int pattern, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, word_val(pattern, k));
        end
    endtask

    task automatic check_output(input string tag, input logic observed, input logic expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
        end
    endtask

    task automatic check_cfg(input string tag, input logic [CFG_W-1:0] observed,
                             input logic [CFG_W-1:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        zero_cfg = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            exp_a[k*SEL_W +: SEL_W] = SEL_W'(k % NUM_IN);
            exp_c[k*SEL_W +: SEL_W] = SEL_W'((k * 7) % NUM_IN);
        end

        // Reset state
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("reset_busy", io_busy, 1'b0);
        check_output("reset_ready", io_cfg_ready, 1'b0);
        check_output("reset_done", io_done, 1'b0);
        check_output("reset_err", io_err, 1'b0);
        check_cfg("reset_mux", io_mux_configs, zero_cfg);
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);

        // Full load of k%34, done in cycle 47
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        check_output("load_ready", io_cfg_ready, 1'b1);
        for (int k = 0; k < NUM_OUT; k++) begin
            check_output("load_busy", io_busy, 1'b1);
            apply_stimulus(1'b0, 1'b0, 1'b1, word_val(0, k));
        end
        check_output("commit_ready", io_cfg_ready, 1'b0);
        check_output("commit_busy", io_busy, 1'b1);
        check_output("commit_done", io_done, 1'b0);
        check_cfg("mux_before_commit", io_mux_configs, zero_cfg);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("full_done", io_done, 1'b1);
        check_output("full_busy", io_busy, 1'b0);
        check_output("full_err", io_err, 1'b0);
        check_cfg("full_mux", io_mux_configs, exp_a);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("done_one_cycle", io_done, 1'b0);

        // Error load: word 10 = 40, config must stay exp_a
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < NUM_OUT; k++) begin
            if (k == 10) check_output("err_before_bad", io_err, 1'b0);
            if (k == 11) check_output("err_after_bad", io_err, 1'b1);
            apply_stimulus(1'b0, 1'b0, 1'b1, (k == 10) ? SEL_W'(40) : word_val(1, k));
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("err_load_done", io_done, 1'b1);
        check_output("err_load_err", io_err, 1'b1);
        check_cfg("err_load_mux", io_mux_configs, exp_a);

        // Stalled load aborted after word 20
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        check_output("err_cleared_on_start", io_err, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            repeat ($urandom_range(0, 2)) apply_stimulus(1'b0, 1'b0, 1'b0, '0);
            apply_stimulus(1'b0, 1'b0, 1'b1, SEL_W'(5));
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("stall_busy", io_busy, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, '0);
        check_output("abort_busy", io_busy, 1'b0);
        check_output("abort_done", io_done, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("abort_done_late", io_done, 1'b0);
        check_cfg("abort_mux", io_mux_configs, exp_a);

        // Abort coincident with a bad word: the word must be discarded
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        send_words(0, 0, 2);
        apply_stimulus(1'b0, 1'b1, 1'b1, SEL_W'(40));
        check_output("abort_valid_busy", io_busy, 1'b0);
        check_output("abort_valid_err", io_err, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("abort_valid_done", io_done, 1'b0);

        // Clean reload starts from index 0
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        send_words(2, 0, NUM_OUT - 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("reload_done", io_done, 1'b1);
        check_cfg("reload_mux", io_mux_configs, exp_c);

        // Reset at word 30 of a load that already flagged an error
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 30; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, (k == 5) ? SEL_W'(50) : word_val(0, k));
        end
        check_output("pre_reset_err", io_err, 1'b1);
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b1, word_val(0, 30));
        check_output("midload_reset_busy", io_busy, 1'b0);
        check_output("midload_reset_ready", io_cfg_ready, 1'b0);
        check_output("midload_reset_done", io_done, 1'b0);
        check_output("midload_reset_err", io_err, 1'b0);
        check_cfg("midload_reset_mux", io_mux_configs, zero_cfg);
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("midload_after_done", io_done, 1'b0);
        check_output("midload_after_busy", io_busy, 1'b0);

        // Reset during COMMIT
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        send_words(0, 0, NUM_OUT - 1);
        check_output("in_commit_busy", io_busy, 1'b1);
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("commit_reset_done", io_done, 1'b0);
        check_output("commit_reset_busy", io_busy, 1'b0);
        check_cfg("commit_reset_mux", io_mux_configs, zero_cfg);
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("commit_reset_done_late", io_done, 1'b0);
        check_cfg("commit_reset_mux_late", io_mux_configs, zero_cfg);

        // Start held through LOAD and COMMIT, abort during COMMIT
        done_seen = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < NUM_OUT; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1, word_val(2, k));
        end
        check_output("held_start_commit_ready", io_cfg_ready, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, '0);
        check_output("held_start_done", io_done, 1'b1);
        check_cfg("held_start_mux", io_mux_configs, exp_c);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("held_start_idle", io_busy, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_cfg("held_start_done_count", CFG_W'(done_seen), CFG_W'(1));

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
